// File: rtl/lp805x_synctrl_mc.sv
`default_nettype none
// ============================================================================
// Module   : lp805x_synctrl_mc
// Purpose  : Multi-channel SFR transfer handshake controller for the lp805x
//            peripheral bus. Each channel runs a hold/accept/put handshake
//            with its peripheral. The CPU side gets one registered data-valid
//            flag and the index of the channel that produced it.
// Options  : LP805X_SYNCTRL_TIMEOUT_EN - when defined, adds a per-channel
//            hold-timeout counter and sticky to_flag bits.
// Ports    : clk        system clock, posedge
//            rst        asynchronous reset, active-high
//            read       CPU SFR read strobe
//            sel        one-hot channel select (lowest set bit wins)
//            sfr_prrdy  per-channel peripheral data ready
//            sfr_pwrdy  per-channel peripheral accept ready
//            sfr_pget   per-channel data-held flag
//            sfr_pput   per-channel consume strobe (1-cycle pulse)
//            sfr_get    CPU fetch request
//            sfr_out    CPU data valid (registered)
//            sfr_ch     index of channel driving sfr_out
//            busy       any channel active or consume pulse pending
//            to_flag    sticky hold-timeout flags
// Revision : 1.0 - initial release
// ============================================================================
module lp805x_synctrl_mc #(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 8,
  parameter int TO_CYC = 200,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            read,
  input  logic [N_CH-1:0] sel,
  input  logic [N_CH-1:0] sfr_prrdy,
  input  logic [N_CH-1:0] sfr_pwrdy,
  output logic [N_CH-1:0] sfr_pget,
  output logic [N_CH-1:0] sfr_pput,
  input  logic            sfr_get,
  output logic            sfr_out,
  output logic [CH_W-1:0] sfr_ch,
  output logic            busy,
  output logic [N_CH-1:0] to_flag
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [N_CH-1:0] pput_q;
  logic [N_CH-1:0] sync_q;
  logic [N_CH-1:0] sync_d;
  logic            sfr_out_q;
  logic            sfr_out_d;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ch_d;

  logic [N_CH-1:0] gsel;
  logic [N_CH-1:0] acc;
  logic [N_CH-1:0] done;
  logic [N_CH-1:0] expire;
  logic [CH_W-1:0] gidx;
  logic            hit;
  logic            any_act;

  // Isolate the lowest set bit of sel so a malformed select can never
  // accept on more than one channel in the same cycle.
  assign gsel = sel & (~sel + N_CH'(1));
  assign acc  = {N_CH{read}} & gsel & sfr_pwrdy;
  assign hit  = |(sync_q & gsel);

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gsel[i]) gidx = CH_W'(i);
    end
  end

`ifdef LP805X_SYNCTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_CYC - 1);

  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  flag_q;
  logic [N_CH-1:0]  flag_d;

  // A pending accept or a fresh prrdy on the last count wins over timeout.
  always_comb begin
    expire = '0;
    flag_d = flag_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i]  = cnt_q[i];
      expire[i] = (state_q[i] == ST_HELD) && (cnt_q[i] == TO_LAST) &&
                  !acc[i] && !sfr_prrdy[i];
      if (sfr_prrdy[i]) begin
        cnt_d[i] = '0;
      end else if ((state_q[i] == ST_HELD) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (state_q[i] == ST_ACK) begin
        flag_d[i] = 1'b0;
      end else if (expire[i]) begin
        flag_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      flag_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
      flag_q <= flag_d;
    end
  end

  assign to_flag = flag_q;
`else
  assign expire  = '0;
  assign to_flag = '0;

  // TO_CYC and CNT_W only size the timeout counters, absent in this build.
  generate
    if ((TO_CYC < 1) || (TO_CYC > (2**CNT_W) - 1)) begin : g_to_cyc_unused
    end
  endgenerate
`endif

  // Next-state: prrdy restarts a transfer from any state, then accept,
  // then ACK retirement, then timeout.
  always_comb begin
    done   = '0;
    sync_d = sync_q;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      if (sfr_prrdy[i]) begin
        state_d[i] = ST_HELD;
      end else if ((state_q[i] == ST_HELD) && acc[i]) begin
        state_d[i] = ST_ACK;
      end else if (state_q[i] == ST_ACK) begin
        state_d[i] = ST_IDLE;
      end else if (expire[i]) begin
        state_d[i] = ST_IDLE;
      end
      // An ACK cancelled by a new prrdy produces neither pput nor sync.
      done[i] = (state_q[i] == ST_ACK) && !sfr_prrdy[i];
      if (done[i]) begin
        sync_d[i] = 1'b1;
      end else if (sfr_prrdy[i]) begin
        sync_d[i] = 1'b0;
      end
    end
    sfr_out_d = sfr_get & hit;
    ch_d      = sfr_out_d ? gidx : ch_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= ST_IDLE;
      pput_q    <= '0;
      sync_q    <= '0;
      sfr_out_q <= 1'b0;
      ch_q      <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) state_q[i] <= state_d[i];
      pput_q    <= done;
      sync_q    <= sync_d;
      sfr_out_q <= sfr_out_d;
      ch_q      <= ch_d;
    end
  end

  always_comb begin
    sfr_pget = '0;
    any_act  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      sfr_pget[i] = (state_q[i] == ST_HELD);
      if (state_q[i] != ST_IDLE) any_act = 1'b1;
    end
  end

  assign sfr_pput = pput_q;
  assign sfr_out  = sfr_out_q;
  assign sfr_ch   = ch_q;
  assign busy     = any_act | (|pput_q);

endmodule
`default_nettype wire

// File: tb/tb_lp805x_synctrl_mc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lp805x_synctrl_mc
// Purpose  : Scoreboard bench for lp805x_synctrl_mc. The driver applies
//            directed and random stimulus, an event-time reference model
//            predicts the next-cycle outputs and queues them, and a monitor
//            pops and compares each cycle. Honours LP805X_SYNCTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lp805x_synctrl_mc;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int TO_CYC = 5;
`ifdef LP805X_SYNCTRL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       read = 1'b0;
  logic       sfr_get = 1'b0;
  logic [3:0] sel = '0;
  logic [3:0] sfr_prrdy = '0;
  logic [3:0] sfr_pwrdy = '0;
  logic [3:0] sfr_pget;
  logic [3:0] sfr_pput;
  logic       sfr_out;
  logic [1:0] sfr_ch;
  logic       busy;
  logic [3:0] to_flag;

  lp805x_synctrl_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .rst(rst), .read(read), .sel(sel),
    .sfr_prrdy(sfr_prrdy), .sfr_pwrdy(sfr_pwrdy),
    .sfr_pget(sfr_pget), .sfr_pput(sfr_pput), .sfr_get(sfr_get),
    .sfr_out(sfr_out), .sfr_ch(sfr_ch), .busy(busy), .to_flag(to_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] pget;
    logic [3:0] pput;
    logic [3:0] tflag;
    logic       out;
    logic [1:0] ch;
    logic       busy;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: each channel remembers when its hold began, the cycle
  // in which it was accepted and the cycle of its consume pulse.
  int hold_start [N_CH];
  int accept_cyc [N_CH];
  int pput_cyc   [N_CH];
  bit synced     [N_CH];
  bit tflag      [N_CH];
  bit m_out;
  int m_ch;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      hold_start[i] = -1;
      accept_cyc[i] = -1;
      pput_cyc[i]   = -1;
      synced[i]     = 1'b0;
      tflag[i]      = 1'b0;
    end
    m_out = 1'b0;
    m_ch  = 0;
  endtask

  // Apply the rules for inputs seen during cycle c; queue outputs for c+1.
  task automatic step(input int c);
    int   g;
    bit   hit;
    bit   in_hold;
    bit   acked;
    bit   acc;
    exp_t e;
    g = -1;
    for (int i = N_CH - 1; i >= 0; i--) if (sel[i]) g = i;
    hit = sfr_get && (g >= 0) && synced[g];
    for (int i = 0; i < N_CH; i++) begin
      in_hold = (hold_start[i] >= 0);
      acked   = (accept_cyc[i] >= 0) && (accept_cyc[i] == c - 1);
      acc     = read && (g == i) && sfr_pwrdy[i];
      if (acked) tflag[i] = 1'b0;
      if (acked && !sfr_prrdy[i]) begin
        pput_cyc[i] = c + 1;
        synced[i]   = 1'b1;
      end
      if (sfr_prrdy[i]) begin
        hold_start[i] = c + 1;
        synced[i]     = 1'b0;
      end else if (in_hold && acc) begin
        accept_cyc[i] = c;
        hold_start[i] = -1;
      end else if (TO_EN && in_hold && (c - hold_start[i] == TO_CYC - 1)) begin
        hold_start[i] = -1;
        tflag[i]      = 1'b1;
      end
    end
    m_out = hit;
    if (hit) m_ch = g;
    e.cyc  = c + 1;
    e.busy = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      e.pget[i]  = (hold_start[i] >= 0);
      e.pput[i]  = (pput_cyc[i] == c + 1);
      e.tflag[i] = tflag[i];
      if (e.pget[i] || e.pput[i] || (accept_cyc[i] == c)) e.busy = 1'b1;
    end
    e.out = m_out;
    e.ch  = m_ch[1:0];
    sbq.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [3:0] s, input logic [3:0] pr,
                       input logic [3:0] pw, input logic g);
    @(posedge clk);
    #1;
    read      = r;
    sel       = s;
    sfr_prrdy = pr;
    sfr_pwrdy = pw;
    sfr_get   = g;
    step(cyc);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1);
  endtask

  // Monitor: reset values while rst is high, otherwise queued predictions.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (rst) begin
        sbq.delete();
        n_chk++;
        if (sfr_pget !== 4'b0 || sfr_pput !== 4'b0 || sfr_out !== 1'b0 ||
            sfr_ch !== 2'b0 || busy !== 1'b0 || to_flag !== 4'b0) begin
          n_fail++;
          $display("FAIL reset t=%0t got pget=%b pput=%b out=%b ch=%0d busy=%b to=%b required all 0",
                   $time, sfr_pget, sfr_pput, sfr_out, sfr_ch, busy, to_flag);
        end
      end else begin
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
          e = sbq.pop_front();
          n_chk++;
          n_fail++;
          $display("FAIL stale_expect cyc=%0d expectation for cyc %0d never compared", cyc, e.cyc);
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
          e = sbq.pop_front();
          n_chk++;
          if (sfr_pget !== e.pget || sfr_pput !== e.pput || sfr_out !== e.out ||
              sfr_ch !== e.ch || busy !== e.busy || to_flag !== e.tflag) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d got pget=%b pput=%b out=%b ch=%0d busy=%b to=%b required pget=%b pput=%b out=%b ch=%0d busy=%b to=%b",
                     cyc, sfr_pget, sfr_pput, sfr_out, sfr_ch, busy, to_flag,
                     e.pget, e.pput, e.out, e.ch, e.busy, e.tflag);
          end
        end
      end
    end
  end

  initial begin : driver
    logic [3:0] pr;
    logic [3:0] s;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single transfer on channel 2 with the CPU fetch held.
    drive(1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b1);
    drive(1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1);

    // Non-one-hot select: only the lowest channel accepts.
    drive(1'b0, 4'b0000, 4'b0110, 4'b0000, 1'b0);
    drive(1'b1, 4'b0110, 4'b0000, 4'b0110, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b1);

    // prrdy on the ACK cycle cancels the consume pulse and sync.
    drive(1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    drive(1'b0, 4'b0001, 4'b0001, 4'b0000, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b0, 4'b0001, 4'b0000, 4'b0000, 1'b1);

    // Long hold on channel 3 (times out only when the option is built in),
    // then a fresh transfer that clears any timeout flag.
    drive(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    idle(1000);
    drive(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    idle(4);
    drive(1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    idle(4);
    // New prrdy on the would-be expiry cycle.
    drive(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    idle(4);
    drive(1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    idle(8);

    // Asynchronous reset in the middle of live transfers.
    drive(1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b0);
    drive(1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    #2;
    rst       = 1'b1;
    read      = 1'b0;
    sel       = '0;
    sfr_prrdy = '0;
    sfr_pwrdy = '0;
    sfr_get   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Randomised traffic.
    for (int k = 0; k < 3000; k++) begin
      pr = '0;
      for (int i = 0; i < N_CH; i++) pr[i] = ($urandom_range(0, 9) == 0);
      s = 4'($urandom);
      if ($urandom_range(0, 1) == 1) s = 4'b0001 << $urandom_range(0, 3);
      drive(1'($urandom_range(0, 1)), s, pr, 4'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    idle(3);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
